// File: rtl/exe_stage.sv
// exe_stage: execute stage with operand forwarding, shifter, ALU, status register and EX/MEM register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic        B_IN,
  input  logic        S_IN,
  input  logic        imm_IN,
  input  logic [3:0]  EXE_CMD_IN,
  input  logic [3:0]  SR_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] Val_Rn_IN,
  input  logic [31:0] Val_Rm_IN,
  input  logic [11:0] Shift_operand_IN,
  input  logic [23:0] Signed_imm_24_IN,
  input  logic [3:0]  Dest_IN,
  input  logic [1:0]  Sel_Src1,
  input  logic [1:0]  Sel_Src2,
  input  logic [31:0] MEM_ALU_Res,
  input  logic [31:0] WB_Value,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  SR,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] ST_Val,
  output logic [3:0]  Dest
);
  logic [31:0] op1, st_op, val2, asr, res;
  logic [63:0] imm_rot, reg_rot;
  logic [32:0] sum;
  logic [4:0]  amt;
  logic        is_add, is_sub, is_log, cin, c, v;
  logic [3:0]  flags;
  logic [3:0]  sr_q, sr_d, dest_q, dest_d;
  logic        wb_en_q, wb_en_d, mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d;
  logic [31:0] alu_res_q, alu_res_d, st_val_q, st_val_d;
  always_comb begin
    op1 = Sel_Src1 == 2'b01 ? MEM_ALU_Res : Sel_Src1 == 2'b10 ? WB_Value : Val_Rn_IN;
    st_op = Sel_Src2 == 2'b01 ? MEM_ALU_Res : Sel_Src2 == 2'b10 ? WB_Value : Val_Rm_IN;
    amt = Shift_operand_IN[11:7];
    imm_rot = {24'd0, Shift_operand_IN[7:0], 24'd0, Shift_operand_IN[7:0]} >> {Shift_operand_IN[11:8], 1'b0};
    reg_rot = {st_op, st_op} >> amt;
    asr = $signed(st_op) >>> amt;
    val2 = imm_IN ? imm_rot[31:0] :
           (MEM_R_EN_IN || MEM_W_EN_IN) ? {20'd0, Shift_operand_IN} :
           Shift_operand_IN[6:5] == 2'b00 ? st_op << amt :
           Shift_operand_IN[6:5] == 2'b01 ? st_op >> amt :
           Shift_operand_IN[6:5] == 2'b10 ? asr : reg_rot[31:0];
    is_add = EXE_CMD_IN == 4'b0010 || EXE_CMD_IN == 4'b0011;
    is_sub = EXE_CMD_IN == 4'b0100 || EXE_CMD_IN == 4'b0101;
    is_log = EXE_CMD_IN == 4'b0001 || EXE_CMD_IN == 4'b1001 || EXE_CMD_IN == 4'b0110 ||
             EXE_CMD_IN == 4'b0111 || EXE_CMD_IN == 4'b1000;
    // subtract is Op1 + ~Val2 + cin, so SBC's borrow (~C) becomes a carry-in of C
    cin = EXE_CMD_IN == 4'b0100 ? 1'b1 : (EXE_CMD_IN == 4'b0011 || EXE_CMD_IN == 4'b0101) ? SR_IN[1] : 1'b0;
    sum = {1'b0, op1} + {1'b0, is_sub ? ~val2 : val2} + {32'd0, cin};
    res = (is_add || is_sub) ? sum[31:0] :
          EXE_CMD_IN == 4'b0001 ? val2 :
          EXE_CMD_IN == 4'b1001 ? ~val2 :
          EXE_CMD_IN == 4'b0110 ? op1 & val2 :
          EXE_CMD_IN == 4'b0111 ? op1 | val2 :
          EXE_CMD_IN == 4'b1000 ? op1 ^ val2 : 32'd0;
    c = (is_add || is_sub) ? sum[32] : SR_IN[1];
    v = is_add ? (op1[31] == val2[31] && res[31] != op1[31]) :
        is_sub ? (op1[31] != val2[31] && res[31] != op1[31]) : SR_IN[0];
    flags = (is_add || is_sub || is_log) ? {res[31], res == 32'd0, c, v} : SR_IN;
    sr_d = (!freeze && S_IN) ? flags : sr_q;
    wb_en_d = freeze ? wb_en_q : WB_EN_IN;
    mem_r_en_d = freeze ? mem_r_en_q : MEM_R_EN_IN;
    mem_w_en_d = freeze ? mem_w_en_q : MEM_W_EN_IN;
    alu_res_d = freeze ? alu_res_q : res;
    st_val_d = freeze ? st_val_q : st_op;
    dest_d = freeze ? dest_q : Dest_IN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr_q <= '0;
      wb_en_q <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q <= '0;
      st_val_q <= '0;
      dest_q <= '0;
    end else begin
      sr_q <= sr_d;
      wb_en_q <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      alu_res_q <= alu_res_d;
      st_val_q <= st_val_d;
      dest_q <= dest_d;
    end
  assign Branch_Taken = B_IN;
  assign Branch_Address = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};
  assign SR = sr_q;
  assign WB_EN = wb_en_q;
  assign MEM_R_EN = mem_r_en_q;
  assign MEM_W_EN = mem_w_en_q;
  assign ALU_Res = alu_res_q;
  assign ST_Val = st_val_q;
  assign Dest = dest_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized scoreboard bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
  logic clk = 0, rst = 0, freeze = 0;
  logic WB_EN_IN = 0, MEM_R_EN_IN = 0, MEM_W_EN_IN = 0, B_IN = 0, S_IN = 0, imm_IN = 0;
  logic [3:0] EXE_CMD_IN = 0, SR_IN = 0, Dest_IN = 0;
  logic [31:0] PC_IN = 0, Val_Rn_IN = 0, Val_Rm_IN = 0, MEM_ALU_Res = 0, WB_Value = 0;
  logic [11:0] Shift_operand_IN = 0;
  logic [23:0] Signed_imm_24_IN = 0;
  logic [1:0] Sel_Src1 = 0, Sel_Src2 = 0;
  logic Branch_Taken, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] Branch_Address, ALU_Res, ST_Val;
  logic [3:0] SR, Dest;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN),
    .MEM_W_EN_IN(MEM_W_EN_IN), .B_IN(B_IN), .S_IN(S_IN), .imm_IN(imm_IN), .EXE_CMD_IN(EXE_CMD_IN),
    .SR_IN(SR_IN), .PC_IN(PC_IN), .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN), .Dest_IN(Dest_IN),
    .Sel_Src1(Sel_Src1), .Sel_Src2(Sel_Src2), .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
    .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address), .SR(SR), .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .ALU_Res(ALU_Res), .ST_Val(ST_Val), .Dest(Dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic freeze, wb, mr, mw, b, s, imm;
    logic [3:0] cmd, sr_in, dest;
    logic [1:0] sel1, sel2;
    logic [31:0] pc, rn, rm, mres, wbv;
    logic [11:0] shop;
    logic [23:0] simm;
  } stim_t;
  typedef struct {
    logic wb, mr, mw;
    logic [31:0] alu, st;
    logic [3:0] dest, sr;
  } out_t;

  out_t q[$];
  out_t ms;
  int checks = 0, passes = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
  endtask

  function automatic logic [31:0] ror(logic [31:0] x, int n);
    for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] asr(logic [31:0] x, int n);
    for (int i = 0; i < n; i++) x = {x[31], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] r, logic [31:0] m, logic [31:0] w);
    return sel == 2'b01 ? m : sel == 2'b10 ? w : r;
  endfunction

  function automatic logic [31:0] val2_of(stim_t s, logic [31:0] st);
    int amt;
    amt = int'(s.shop[11:7]);
    if (s.imm) return ror({24'd0, s.shop[7:0]}, 2 * int'(s.shop[11:8]));
    if (s.mr || s.mw) return {20'd0, s.shop};
    case (s.shop[6:5])
      2'b00: return st << amt;
      2'b01: return st >> amt;
      2'b10: return asr(st, amt);
      default: return ror(st, amt);
    endcase
  endfunction

  // returns {result, N, Z, C, V} using wide integer arithmetic
  function automatic logic [35:0] alu(logic [3:0] cmd, logic [31:0] a, logic [31:0] b, logic [3:0] sr);
    longint ua, ub, sa, sb, cy, u, sg;
    logic [31:0] r;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cy = longint'(sr[1]);
    c = sr[1];
    v = sr[0];
    u = 0;
    sg = 0;
    r = 32'd0;
    case (cmd)
      4'h1: r = b;
      4'h9: r = ~b;
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h2: begin u = ua + ub; sg = sa + sb; end
      4'h3: begin u = ua + ub + cy; sg = sa + sb + cy; end
      4'h4: begin u = ua - ub; sg = sa - sb; end
      4'h5: begin u = ua - ub - (1 - cy); sg = sa - sb - (1 - cy); end
      default: return {32'd0, sr};
    endcase
    if (cmd inside {[4'h2:4'h5]}) begin
      r = u[31:0];
      c = cmd[2] ? (u >= 0) : (u >= 64'sd4294967296);
      v = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    end
    return {r, r[31], r == 32'd0, c, v};
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] r32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.freeze = $urandom_range(0, 4) == 0;
    s.wb = 1'($urandom);
    s.mr = $urandom_range(0, 3) == 0;
    s.mw = $urandom_range(0, 3) == 0;
    s.b = 1'($urandom);
    s.s = 1'($urandom);
    s.imm = 1'($urandom);
    s.cmd = 4'($urandom);
    s.sr_in = 4'($urandom);
    s.dest = 4'($urandom);
    s.sel1 = 2'($urandom);
    s.sel2 = 2'($urandom);
    s.pc = $urandom;
    s.rn = r32();
    s.rm = r32();
    s.mres = r32();
    s.wbv = r32();
    s.shop = 12'($urandom);
    s.simm = 24'($urandom);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    logic [31:0] op1, st, v2, ba;
    logic [35:0] al;
    @(negedge clk);
    rst = 1;
    freeze = s.freeze; WB_EN_IN = s.wb; MEM_R_EN_IN = s.mr; MEM_W_EN_IN = s.mw;
    B_IN = s.b; S_IN = s.s; imm_IN = s.imm; EXE_CMD_IN = s.cmd; SR_IN = s.sr_in; Dest_IN = s.dest;
    Sel_Src1 = s.sel1; Sel_Src2 = s.sel2; PC_IN = s.pc; Val_Rn_IN = s.rn; Val_Rm_IN = s.rm;
    MEM_ALU_Res = s.mres; WB_Value = s.wbv; Shift_operand_IN = s.shop; Signed_imm_24_IN = s.simm;
    op1 = fwd(s.sel1, s.rn, s.mres, s.wbv);
    st = fwd(s.sel2, s.rm, s.mres, s.wbv);
    v2 = val2_of(s, st);
    al = alu(s.cmd, op1, v2, s.sr_in);
    if (!s.freeze) begin
      ms.wb = s.wb; ms.mr = s.mr; ms.mw = s.mw;
      ms.alu = al[35:4]; ms.st = st; ms.dest = s.dest;
      if (s.s) ms.sr = al[3:0];
    end
    q.push_back(ms);
    ba = s.pc + 32'(longint'($signed(s.simm)) * 4);
    #1;
    chk("br_taken", {31'd0, Branch_Taken}, {31'd0, s.b});
    chk("br_addr", Branch_Address, ba);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    freeze = 1;
    #1;
    chk("rst_alu", ALU_Res, 32'd0);
    chk("rst_st", ST_Val, 32'd0);
    chk("rst_sr", {28'd0, SR}, 32'd0);
    chk("rst_ctl", {25'd0, WB_EN, MEM_R_EN, MEM_W_EN, Dest}, 32'd0);
    ms = '{default: '0};
    q.push_back(ms);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      out_t e;
      e = q.pop_front();
      chk("sb_alu", ALU_Res, e.alu);
      chk("sb_st", ST_Val, e.st);
      chk("sb_sr", {28'd0, SR}, {28'd0, e.sr});
      chk("sb_ctl", {25'd0, WB_EN, MEM_R_EN, MEM_W_EN, Dest}, {25'd0, e.wb, e.mr, e.mw, e.dest});
    end
  end

  initial begin
    stim_t s;
    ms = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    chk("init_alu", ALU_Res, 32'd0);
    chk("init_st", ST_Val, 32'd0);
    chk("init_sr", {28'd0, SR}, 32'd0);
    chk("init_ctl", {25'd0, WB_EN, MEM_R_EN, MEM_W_EN, Dest}, 32'd0);
    s = base(); s.rn = 32'h7FFFFFFF; s.cmd = 4'h2; s.imm = 1; s.shop = 12'h001; s.s = 1;
    drive(s); settle();
    chk("add_ovf_res", ALU_Res, 32'h80000000);
    chk("add_ovf_sr", {28'd0, SR}, 32'h9);
    s = base(); s.rn = 32'd5; s.cmd = 4'h4; s.imm = 1; s.shop = 12'h005; s.s = 1;
    drive(s); settle();
    chk("sub_eq_res", ALU_Res, 32'd0);
    chk("sub_eq_sr", {28'd0, SR}, 32'h6);
    s.s = 0; s.sr_in = 4'hF;
    drive(s); settle();
    chk("sub_nos_sr", {28'd0, SR}, 32'h6);
    s = base(); s.rn = 32'h7FFFFFFF; s.cmd = 4'h2; s.imm = 1; s.shop = 12'h001;
    drive(s); settle();
    chk("add_nos_sr", {28'd0, SR}, 32'h6);
    s = base(); s.cmd = 4'h1; s.imm = 1; s.shop = 12'h2FF;
    drive(s); settle();
    chk("imm_rot", ALU_Res, 32'hF000000F);
    s = base(); s.cmd = 4'h1; s.rm = 32'h80000000; s.shop = 12'h220;
    drive(s); settle();
    chk("lsr4", ALU_Res, 32'h08000000);
    s.shop = 12'h240;
    drive(s); settle();
    chk("asr4", ALU_Res, 32'hF8000000);
    s = base(); s.sel1 = 2'b01; s.mres = 32'h10; s.rn = 32'h55; s.cmd = 4'h2; s.imm = 1; s.shop = 12'h004;
    drive(s); settle();
    chk("fwd_mem", ALU_Res, 32'h14);
    s = base(); s.sel2 = 2'b10; s.wbv = 32'hCAFEBABE; s.rm = 32'h1234; s.mw = 1; s.cmd = 4'h2;
    drive(s); settle();
    chk("fwd_wb_st", ST_Val, 32'hCAFEBABE);
    s = base(); s.cmd = 4'h1; s.imm = 1; s.shop = 12'h0AB;
    drive(s);
    repeat (2) begin
      s = rnd(); s.freeze = 1; s.s = 1;
      drive(s);
    end
    settle();
    chk("freeze_hold", ALU_Res, 32'h000000AB);
    s = rnd(); s.freeze = 0;
    drive(s);
    s = base(); s.b = 1; s.pc = 32'h100; s.simm = 24'hFFFFFE;
    drive(s);
    chk("br_back", Branch_Address, 32'h000000F8);
    s = rnd(); s.freeze = 0; s.wb = 1; s.rm = 32'hDEADBEEF; s.sel2 = 2'b00;
    drive(s);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else drive(rnd());
    end
    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
